cache_mem_arbiter: RTL and testbench
====================================

# cache_mem_arbiter

Shared refill/write-back controller between the instruction cache, the data cache and the single 32-bit memory port. It accepts 256-bit line read requests from the icache and dcache, and line write-back requests from the dcache. It grants one at a time by fixed priority and sequences each line as an 8-beat 32-bit burst on the memory side. Read beats are assembled into a 256-bit line, which is returned to the requester with a one-cycle valid pulse.

## Interface
Parameters:
- LINE_BEATS, 8, beats per cache line (line = LINE_BEATS×32 bits)
- ADDR_W, 32, address width

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- icache_rd_req  in  1  icache line read request, level, held until serviced
- icache_rd_addr  in  32  icache miss address
- icache_ret_valid  out  1  one-cycle pulse, icache_ret_data valid
- icache_ret_data  out  256  refilled line, beat i in bits [32i+31:32i]
- dcache_rd_req  in  1  dcache line read request, level
- dcache_rd_addr  in  32  dcache miss address
- dcache_ret_valid  out  1  one-cycle pulse
- dcache_ret_data  out  256  refilled line
- dcache_wr_req  in  1  dcache dirty-line write-back request, level
- dcache_wr_addr  in  32  victim line address
- dcache_wr_data  in  256  victim line, must be held stable until dcache_wr_done
- dcache_wr_done  out  1  one-cycle pulse, write-back complete
- mem_req  out  1  memory address-phase request
- mem_we  out  1  1 = write burst, 0 = read burst
- mem_addr  out  32  burst start address, bits [4:0] forced to 0
- mem_addr_ok  in  1  address phase accepted
- mem_wdata  out  32  current write beat
- mem_rdata  in  32  current read beat
- mem_data_ok  in  1  beat transferred (read data valid / write beat consumed)

## Operation
- States: IDLE, ADDR, DATA, RESP.
- IDLE:
  - Sample requests with priority dcache_wr_req > dcache_rd_req > icache_rd_req. Write-back precedes refill so an evicted dirty line reaches memory before the same set is re-read.
  - On any request: latch grant owner, line address (addr & ~32'h1F) and mem_we; clear beat counter; go to ADDR.
- ADDR: mem_req=1 with latched mem_addr/mem_we. On mem_addr_ok, go to DATA.
- DATA: each mem_data_ok advances the 3-bit beat counter.
  - Read: mem_rdata is written into line buffer slot [counter].
  - Write: mem_wdata = dcache_wr_data[32·counter+31 : 32·counter].
  - When mem_data_ok occurs at counter = LINE_BEATS−1, go to RESP.
- RESP: pulse exactly one of icache_ret_valid, dcache_ret_valid, dcache_wr_done, according to the owner. Return to IDLE.
- icache_ret_data and dcache_ret_data both drive the shared line buffer. It holds its value until the next read burst starts writing it.
- Requests arriving during a transaction are not lost. They stay pending (level) and are arbitrated on the next IDLE cycle.
- A granted transaction always completes and always produces its response pulse, even if the requester drops its request mid-burst (e.g. branch flush). The requester discards unwanted data.
- Requests are not re-sampled in RESP. A requester that lowers req in the cycle after its pulse is never serviced twice.
- Only one memory transaction is outstanding. No interleaving, no beat reordering.
- A fixed-priority starvation of the icache is accepted: the dcache issues at most one write-back plus one refill per miss.

## Timing
- Reset (synchronous): state=IDLE, counter=0, line buffer=0. mem_req, mem_we, mem_addr, mem_wdata, all ret_valid/wr_done outputs = 0. Any memory transaction in progress is abandoned.
- Latency with zero-wait memory (mem_addr_ok and mem_data_ok high every cycle), request first seen at cycle 0:
  - cycle 1: mem_req=1
  - cycles 2–9: beats 0–7
  - cycle 10: response pulse
  - cycle 11: IDLE, next grant possible
- Minimum request-to-request turnaround is 11 cycles.
- mem_req is high only in ADDR; mem_addr and mem_we are stable throughout ADDR and DATA.
- mem_data_ok outside DATA is ignored. mem_addr_ok outside ADDR is ignored.
- Response pulses are registered: exactly one cycle wide and mutually exclusive.

## Test plan
- Single icache refill, addr 0x1C00_0044, zero-wait memory, rdata = beat index:
  - mem_addr = 0x1C00_0040 and mem_we = 0 in cycle 1.
  - icache_ret_valid at cycle 10 with data = {32'd7,…,32'd0}.
  - No dcache pulse.
- Simultaneous dcache_wr_req (0x8000_0020), dcache_rd_req and icache_rd_req:
  - Service order is write, dcache read, icache read.
  - dcache_wr_done, then dcache_ret_valid, then icache_ret_valid; each request stays held until its own pulse.
- Write-back with dcache_wr_data beat i = 0xA0+i, mem_data_ok asserted every other cycle:
  - mem_wdata sequences 0xA0…0xA7, each held until accepted.
  - dcache_wr_done pulses once after the 8th accept.
- mem_addr_ok delayed 5 cycles:
  - mem_req stays high for 6 cycles with a constant address.
  - No beat is captured before the address phase is accepted.
- icache_rd_req dropped at beat 3:
  - Burst completes all 8 beats and icache_ret_valid still pulses once.
  - A new icache request afterwards is serviced normally.
- reset asserted at beat 4 of a read:
  - All outputs are 0 the next cycle; state IDLE.
  - A fresh request after reset is serviced from beat 0.

Source files
------------

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter
// Shared refill / write-back controller between the icache, the dcache and a
// single 32-bit memory port. One line transaction at a time, fixed priority
// dcache write-back > dcache refill > icache refill. Each line moves as a
// LINE_BEATS-beat 32-bit burst; refill beats are assembled into a shared line
// buffer and the owner receives a one-cycle registered response pulse.
//
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   icache_rd_req/addr           icache line read request (level) and address
//   icache_ret_valid/data        icache refill pulse and line
//   dcache_rd_req/addr           dcache line read request (level) and address
//   dcache_ret_valid/data        dcache refill pulse and line
//   dcache_wr_req/addr/data      dcache write-back request, address, victim line
//   dcache_wr_done               write-back complete pulse
//   mem_req/we/addr              memory address phase (line-aligned address)
//   mem_addr_ok                  address phase accepted
//   mem_wdata/rdata/data_ok      memory data beats
module cache_mem_arbiter #(
  parameter int unsigned LINE_BEATS = 8,
  parameter int unsigned ADDR_W     = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     icache_rd_req,
  input  logic [ADDR_W-1:0]        icache_rd_addr,
  output logic                     icache_ret_valid,
  output logic [LINE_BEATS*32-1:0] icache_ret_data,
  input  logic                     dcache_rd_req,
  input  logic [ADDR_W-1:0]        dcache_rd_addr,
  output logic                     dcache_ret_valid,
  output logic [LINE_BEATS*32-1:0] dcache_ret_data,
  input  logic                     dcache_wr_req,
  input  logic [ADDR_W-1:0]        dcache_wr_addr,
  input  logic [LINE_BEATS*32-1:0] dcache_wr_data,
  output logic                     dcache_wr_done,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic                     mem_addr_ok,
  output logic [31:0]              mem_wdata,
  input  logic [31:0]              mem_rdata,
  input  logic                     mem_data_ok
);

  localparam int unsigned LINE_W = LINE_BEATS * 32;
  localparam int unsigned CNT_W  = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_BEATS - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  localparam logic [1:0] OWN_ICACHE   = 2'd0;
  localparam logic [1:0] OWN_DCACHE_R = 2'd1;
  localparam logic [1:0] OWN_DCACHE_W = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [1:0]        owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic              ival_q, ival_d;
  logic              dval_q, dval_d;
  logic              wdone_q, wdone_d;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    we_d    = we_q;
    cnt_d   = cnt_q;
    line_d  = line_q;
    ival_d  = 1'b0;
    dval_d  = 1'b0;
    wdone_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Write-back first so a dirty victim reaches memory before its set is re-read.
        if (dcache_wr_req) begin
          owner_d = OWN_DCACHE_W;
          addr_d  = {dcache_wr_addr[ADDR_W-1:5], 5'b0};
          we_d    = 1'b1;
          cnt_d   = '0;
          state_d = ST_ADDR;
        end else if (dcache_rd_req) begin
          owner_d = OWN_DCACHE_R;
          addr_d  = {dcache_rd_addr[ADDR_W-1:5], 5'b0};
          we_d    = 1'b0;
          cnt_d   = '0;
          state_d = ST_ADDR;
        end else if (icache_rd_req) begin
          owner_d = OWN_ICACHE;
          addr_d  = {icache_rd_addr[ADDR_W-1:5], 5'b0};
          we_d    = 1'b0;
          cnt_d   = '0;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (mem_addr_ok) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (mem_data_ok) begin
          if (!we_q) line_d[32*cnt_q +: 32] = mem_rdata;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BEAT) begin
            state_d = ST_RESP;
            // Pulses are registered here so they appear exactly in the RESP cycle.
            ival_d  = (owner_q == OWN_ICACHE);
            dval_d  = (owner_q == OWN_DCACHE_R);
            wdone_d = (owner_q == OWN_DCACHE_W);
          end
        end
      end
      ST_RESP: begin
        // Requests are deliberately not sampled here; a requester dropping req
        // the cycle after its pulse is never granted twice.
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_ICACHE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
      line_q  <= '0;
      ival_q  <= 1'b0;
      dval_q  <= 1'b0;
      wdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
      line_q  <= line_d;
      ival_q  <= ival_d;
      dval_q  <= dval_d;
      wdone_q <= wdone_d;
    end
  end

  assign mem_req          = (state_q == ST_ADDR);
  assign mem_we           = we_q;
  assign mem_addr         = addr_q;
  assign mem_wdata        = (state_q == ST_DATA && we_q) ? dcache_wr_data[32*cnt_q +: 32] : 32'h0;
  assign icache_ret_valid = ival_q;
  assign dcache_ret_valid = dval_q;
  assign dcache_wr_done   = wdone_q;
  assign icache_ret_data  = line_q;
  assign dcache_ret_data  = line_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter
// Directed bench for cache_mem_arbiter. A behavioural memory task (serve)
// answers one burst and records what it saw; each test task compares those
// observations against hand-computed values.
module tb_cache_mem_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic         icache_rd_req;
  logic [31:0]  icache_rd_addr;
  logic         icache_ret_valid;
  logic [255:0] icache_ret_data;
  logic         dcache_rd_req;
  logic [31:0]  dcache_rd_addr;
  logic         dcache_ret_valid;
  logic [255:0] dcache_ret_data;
  logic         dcache_wr_req;
  logic [31:0]  dcache_wr_addr;
  logic [255:0] dcache_wr_data;
  logic         dcache_wr_done;
  logic         mem_req;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic         mem_addr_ok;
  logic [31:0]  mem_wdata;
  logic [31:0]  mem_rdata;
  logic         mem_data_ok;

  cache_mem_arbiter #(.LINE_BEATS(8), .ADDR_W(32)) dut (
    .clk              (clk),
    .reset            (reset),
    .icache_rd_req    (icache_rd_req),
    .icache_rd_addr   (icache_rd_addr),
    .icache_ret_valid (icache_ret_valid),
    .icache_ret_data  (icache_ret_data),
    .dcache_rd_req    (dcache_rd_req),
    .dcache_rd_addr   (dcache_rd_addr),
    .dcache_ret_valid (dcache_ret_valid),
    .dcache_ret_data  (dcache_ret_data),
    .dcache_wr_req    (dcache_wr_req),
    .dcache_wr_addr   (dcache_wr_addr),
    .dcache_wr_data   (dcache_wr_data),
    .dcache_wr_done   (dcache_wr_done),
    .mem_req          (mem_req),
    .mem_we           (mem_we),
    .mem_addr         (mem_addr),
    .mem_addr_ok      (mem_addr_ok),
    .mem_wdata        (mem_wdata),
    .mem_rdata        (mem_rdata),
    .mem_data_ok      (mem_data_ok)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Observations recorded by serve
  int           cyc, pulse_cyc, n_ival, n_dval, n_wdone, req_cycles, addr_changes;
  logic [31:0]  obs_addr;
  logic         obs_we;
  logic [255:0] obs_line;
  logic         timed_out;
  logic [31:0]  wq[$];
  logic [255:0] exp_line;

  // Cycle 1 is the first negedge after the request is first sampled.
  task automatic serve(input int addr_delay, input int gap, input logic [31:0] rbase,
                       input int drop_beat, input int reset_beat);
    int phase = 0;
    int beat  = 0;
    int ad    = 0;
    int dc    = 0;
    int post  = 0;
    cyc = 0; pulse_cyc = -1; n_ival = 0; n_dval = 0; n_wdone = 0;
    req_cycles = 0; addr_changes = 0; timed_out = 1'b0; obs_line = '0;
    obs_addr = '0; obs_we = 1'b0;
    wq.delete();
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'h0;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (cyc > 300) begin timed_out = 1'b1; break; end
      if (icache_ret_valid) begin
        n_ival++; pulse_cyc = cyc; obs_line = icache_ret_data; icache_rd_req = 1'b0;
      end
      if (dcache_ret_valid) begin
        n_dval++; pulse_cyc = cyc; obs_line = dcache_ret_data; dcache_rd_req = 1'b0;
      end
      if (dcache_wr_done) begin
        n_wdone++; pulse_cyc = cyc; dcache_wr_req = 1'b0;
      end
      if (phase == 4) break;
      if (phase == 3) begin
        mem_data_ok = 1'b0;
        post++;
        if (post == 2) break;
        continue;
      end
      if (phase == 0 && mem_req) begin
        phase = 1; obs_addr = mem_addr; obs_we = mem_we;
      end
      if (phase == 1) begin
        if (mem_req) req_cycles++;
        if (mem_addr !== obs_addr || mem_we !== obs_we) addr_changes++;
        if (ad == addr_delay) begin
          mem_addr_ok = 1'b1; mem_data_ok = 1'b0; phase = 2;
        end else begin
          // Spurious data_ok with junk data while the address phase is pending
          mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'hDEAD0000; ad++;
        end
        continue;
      end
      if (phase == 2) begin
        mem_addr_ok = 1'b0;
        if (mem_req) req_cycles++;
        if (mem_addr !== obs_addr || mem_we !== obs_we) addr_changes++;
        if (beat == reset_beat) begin
          reset = 1'b1; mem_data_ok = 1'b0; phase = 4;
          continue;
        end
        if (obs_we) wq.push_back(mem_wdata);
        mem_rdata = rbase + beat;
        if (dc % (gap + 1) == gap) begin
          mem_data_ok = 1'b1;
          if (beat == drop_beat) icache_rd_req = 1'b0;
          beat++;
          if (beat == 8) phase = 3;
        end else begin
          mem_data_ok = 1'b0;
        end
        dc++;
      end
    end
    reset = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_mem got req=%b we=%b addr=%h wdata=%h exp all 0",
               mem_req, mem_we, mem_addr, mem_wdata);
    end
    checks++;
    if ({icache_ret_valid, dcache_ret_valid, dcache_wr_done} !== 3'b000 ||
        icache_ret_data !== 256'h0 || dcache_ret_data !== 256'h0) begin
      errors++;
      $display("FAIL reset_resp got pulses=%b%b%b line=%h exp 0", icache_ret_valid,
               dcache_ret_valid, dcache_wr_done, icache_ret_data);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_refill();
    icache_rd_addr = 32'h1C00_0044;
    icache_rd_req  = 1'b1;
    serve(0, 0, 32'h0, -1, -1);
    for (int i = 0; i < 8; i++) exp_line[32*i +: 32] = i;
    checks++;
    if (timed_out || obs_addr !== 32'h1C00_0040 || obs_we !== 1'b0) begin
      errors++;
      $display("FAIL single_addr got addr=%h we=%b to=%b exp addr=1c000040 we=0",
               obs_addr, obs_we, timed_out);
    end
    checks++;
    if (pulse_cyc !== 10 || n_ival !== 1) begin
      errors++;
      $display("FAIL single_latency got cyc=%0d n=%0d exp cyc=10 n=1", pulse_cyc, n_ival);
    end
    checks++;
    if (n_dval !== 0 || n_wdone !== 0) begin
      errors++;
      $display("FAIL single_no_dcache got dval=%0d wdone=%0d exp 0 0", n_dval, n_wdone);
    end
    checks++;
    if (obs_line !== exp_line) begin
      errors++;
      $display("FAIL single_data got %h exp %h", obs_line, exp_line);
    end
  endtask

  task automatic test_priority();
    for (int i = 0; i < 8; i++) dcache_wr_data[32*i +: 32] = 32'h5500 + i;
    dcache_wr_addr = 32'h8000_0020;
    dcache_rd_addr = 32'h0000_1234;
    icache_rd_addr = 32'h2000_0008;
    dcache_wr_req = 1'b1; dcache_rd_req = 1'b1; icache_rd_req = 1'b1;
    serve(0, 0, 32'h0, -1, -1);
    checks++;
    if (n_wdone !== 1 || n_dval !== 0 || n_ival !== 0 || obs_addr !== 32'h8000_0020 ||
        obs_we !== 1'b1) begin
      errors++;
      $display("FAIL prio_first got wd=%0d dv=%0d iv=%0d addr=%h we=%b exp 1 0 0 80000020 1",
               n_wdone, n_dval, n_ival, obs_addr, obs_we);
    end
    serve(0, 0, 32'h100, -1, -1);
    for (int i = 0; i < 8; i++) exp_line[32*i +: 32] = 32'h100 + i;
    checks++;
    if (n_dval !== 1 || n_wdone !== 0 || n_ival !== 0 || obs_addr !== 32'h0000_1220 ||
        obs_we !== 1'b0 || obs_line !== exp_line) begin
      errors++;
      $display("FAIL prio_second got wd=%0d dv=%0d iv=%0d addr=%h line=%h exp 0 1 0 00001220 %h",
               n_wdone, n_dval, n_ival, obs_addr, obs_line, exp_line);
    end
    serve(0, 0, 32'h200, -1, -1);
    for (int i = 0; i < 8; i++) exp_line[32*i +: 32] = 32'h200 + i;
    checks++;
    if (n_ival !== 1 || n_dval !== 0 || n_wdone !== 0 || obs_addr !== 32'h2000_0000 ||
        obs_line !== exp_line || pulse_cyc !== 10) begin
      errors++;
      $display("FAIL prio_third got iv=%0d dv=%0d wd=%0d addr=%h cyc=%0d exp 1 0 0 20000000 10",
               n_ival, n_dval, n_wdone, obs_addr, pulse_cyc);
    end
  endtask

  task automatic test_writeback();
    for (int i = 0; i < 8; i++) dcache_wr_data[32*i +: 32] = 32'hA0 + i;
    dcache_wr_addr = 32'h0000_4000;
    dcache_wr_req  = 1'b1;
    serve(0, 1, 32'h0, -1, -1);
    checks++;
    if (wq.size() !== 16) begin
      errors++;
      $display("FAIL wb_beats got %0d exp 16", wq.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (wq[i] !== 32'hA0 + i / 2) begin
          errors++;
          $display("FAIL wb_wdata[%0d] got %h exp %h", i, wq[i], 32'hA0 + i / 2);
        end
      end
    end
    checks++;
    if (n_wdone !== 1 || pulse_cyc !== 18) begin
      errors++;
      $display("FAIL wb_done got n=%0d cyc=%0d exp 1 18", n_wdone, pulse_cyc);
    end
  endtask

  task automatic test_addr_delay();
    dcache_rd_addr = 32'h0000_0ABC;
    dcache_rd_req  = 1'b1;
    serve(5, 0, 32'h300, -1, -1);
    for (int i = 0; i < 8; i++) exp_line[32*i +: 32] = 32'h300 + i;
    checks++;
    if (req_cycles !== 6 || addr_changes !== 0 || obs_addr !== 32'h0000_0AA0) begin
      errors++;
      $display("FAIL adly_req got cycles=%0d changes=%0d addr=%h exp 6 0 00000aa0",
               req_cycles, addr_changes, obs_addr);
    end
    checks++;
    if (obs_line !== exp_line || n_dval !== 1 || pulse_cyc !== 15) begin
      errors++;
      $display("FAIL adly_data got line=%h n=%0d cyc=%0d exp %h 1 15",
               obs_line, n_dval, pulse_cyc, exp_line);
    end
  endtask

  task automatic test_drop();
    icache_rd_addr = 32'h0000_0040;
    icache_rd_req  = 1'b1;
    serve(0, 0, 32'h500, 3, -1);
    for (int i = 0; i < 8; i++) exp_line[32*i +: 32] = 32'h500 + i;
    checks++;
    if (n_ival !== 1 || obs_line !== exp_line || pulse_cyc !== 10) begin
      errors++;
      $display("FAIL drop_burst got n=%0d cyc=%0d line=%h exp 1 10 %h",
               n_ival, pulse_cyc, obs_line, exp_line);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("FAIL drop_idle got mem_req=%b exp 0", mem_req);
    end
    icache_rd_addr = 32'h0000_0060;
    icache_rd_req  = 1'b1;
    serve(0, 0, 32'h600, -1, -1);
    for (int i = 0; i < 8; i++) exp_line[32*i +: 32] = 32'h600 + i;
    checks++;
    if (n_ival !== 1 || obs_line !== exp_line || obs_addr !== 32'h0000_0060) begin
      errors++;
      $display("FAIL drop_next got n=%0d addr=%h line=%h exp 1 00000060 %h",
               n_ival, obs_addr, obs_line, exp_line);
    end
  endtask

  task automatic test_reset_mid();
    icache_rd_addr = 32'h0000_0080;
    icache_rd_req  = 1'b1;
    serve(0, 0, 32'h700, -1, 4);
    checks++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 ||
        icache_ret_data !== 256'h0 || n_ival !== 0 || icache_ret_valid !== 1'b0) begin
      errors++;
      $display("FAIL rmid_outputs got req=%b addr=%h line=%h pulses=%0d exp 0 0 0 0",
               mem_req, mem_addr, icache_ret_data, n_ival);
    end
    serve(0, 0, 32'h900, -1, -1);
    for (int i = 0; i < 8; i++) exp_line[32*i +: 32] = 32'h900 + i;
    checks++;
    if (n_ival !== 1 || obs_line !== exp_line || pulse_cyc !== 10) begin
      errors++;
      $display("FAIL rmid_fresh got n=%0d cyc=%0d line=%h exp 1 10 %h",
               n_ival, pulse_cyc, obs_line, exp_line);
    end
  endtask

  initial begin
    reset = 1'b1;
    icache_rd_req = 1'b0; icache_rd_addr = 32'h0;
    dcache_rd_req = 1'b0; dcache_rd_addr = 32'h0;
    dcache_wr_req = 1'b0; dcache_wr_addr = 32'h0; dcache_wr_data = '0;
    mem_addr_ok = 1'b0; mem_rdata = 32'h0; mem_data_ok = 1'b0;
    exp_line = '0;
    test_reset();
    test_single_refill();
    test_priority();
    test_writeback();
    test_addr_delay();
    test_drop();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
